// File: rtl/nn_program_sequencer.sv
// Walks the instruction RAM layer list and issues one descriptor per layer.
// Optional NN_SEQ_PERF_EN adds a saturating busy-cycle counter (perf_cycles).
module nn_program_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH = 5,
    parameter logic [DATA_WIDTH-1:0] END_OF_PROGRAM = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            error_code,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic                  imem_en,
    input  logic [DATA_WIDTH-1:0] imem_data,
    output logic                  layer_valid,
    input  logic                  layer_ready,
    output logic [DATA_WIDTH-1:0] layer_in_size,
    output logic [DATA_WIDTH-1:0] layer_out_size,
    output logic [ADDR_WIDTH-1:0] layer_idx,
    input  logic                  layer_done,
    output logic [ADDR_WIDTH-1:0] layers_run
`ifdef NN_SEQ_PERF_EN
    ,
    output logic [15:0]           perf_cycles
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_IN,
        S_FETCH_OUT,
        S_ISSUE,
        S_WAIT_DONE,
        S_FINISH,
        S_ERROR
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] run_q, run_d;
    logic [DATA_WIDTH-1:0] in_q, in_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [1:0]            code_q, code_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  valid_q, valid_d;
    logic                  en_q, en_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        idx_d   = idx_q;
        run_d   = run_q;
        in_d    = in_q;
        out_d   = out_q;
        code_d  = code_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = '0;
                    idx_d   = '0;
                    run_d   = '0;
                    err_d   = 1'b0;
                    code_d  = 2'd0;
                    state_d = S_FETCH_IN;
                end
            end
            S_FETCH_IN: begin
                if (imem_data == END_OF_PROGRAM) begin
                    err_d   = 1'b1;
                    code_d  = 2'd1;
                    state_d = S_ERROR;
                end else if (imem_data == '0) begin
                    err_d   = 1'b1;
                    code_d  = 2'd2;
                    state_d = S_ERROR;
                end else begin
                    in_d    = imem_data;
                    pc_d    = pc_q + 1'b1;
                    state_d = S_FETCH_OUT;
                end
            end
            S_FETCH_OUT: begin
                if (imem_data == END_OF_PROGRAM) begin
                    if (idx_q == '0) begin
                        err_d   = 1'b1;
                        code_d  = 2'd1;
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_FINISH;
                    end
                end else if (imem_data == '0) begin
                    err_d   = 1'b1;
                    code_d  = 2'd2;
                    state_d = S_ERROR;
                end else begin
                    out_d   = imem_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (layer_ready) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (layer_done) begin
                    run_d = run_q + 1'b1;
                    if (pc_q == LAST_ADDR) begin
                        err_d   = 1'b1;
                        code_d  = 2'd3;
                        state_d = S_ERROR;
                    end else begin
                        // Output size chains into the next layer's input.
                        in_d    = out_q;
                        idx_d   = idx_q + 1'b1;
                        pc_d    = pc_q + 1'b1;
                        state_d = S_FETCH_OUT;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            S_ERROR:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_FINISH);
        valid_d = (state_d == S_ISSUE);
        en_d    = (state_d == S_FETCH_IN) || (state_d == S_FETCH_OUT);
        addr_d  = en_d ? pc_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
            run_q   <= '0;
            in_q    <= '0;
            out_q   <= '0;
            code_q  <= 2'd0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            run_q   <= run_d;
            in_q    <= in_d;
            out_q   <= out_d;
            code_q  <= code_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            en_q    <= en_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = err_q;
    assign error_code     = code_q;
    assign imem_addr      = addr_q;
    assign imem_en        = en_q;
    assign layer_valid    = valid_q;
    assign layer_in_size  = in_q;
    assign layer_out_size = out_q;
    assign layer_idx      = idx_q;
    assign layers_run     = run_q;

`ifdef NN_SEQ_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == S_IDLE) begin
            if (start) perf_d = 16'd0;
        end else if (perf_q != 16'hFFFF) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) perf_q <= 16'd0;
        else     perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_nn_program_sequencer.sv
// Bench for nn_program_sequencer: table vectors, stall/reset sequences and
// randomized programs checked against a layer-list model.
module tb_nn_program_sequencer;

    localparam int DEPTH = 5;

    logic       clk = 1'b0;
    logic       rst, start, layer_ready, layer_done;
    logic       busy, done, error, imem_en, layer_valid;
    logic [1:0] error_code;
    logic [7:0] imem_addr, imem_data, layer_in_size, layer_out_size;
    logic [7:0] layer_idx, layers_run;
`ifdef NN_SEQ_PERF_EN
    logic [15:0] perf_cycles;
`endif
    logic [7:0] mem [0:DEPTH-1];

    always #5 clk = ~clk;

    assign imem_data = (imem_addr < 8'(DEPTH)) ? mem[imem_addr[2:0]] : 8'hEE;

    nn_program_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .error(error), .error_code(error_code), .imem_addr(imem_addr),
        .imem_en(imem_en), .imem_data(imem_data),
        .layer_valid(layer_valid), .layer_ready(layer_ready),
        .layer_in_size(layer_in_size), .layer_out_size(layer_out_size),
        .layer_idx(layer_idx), .layer_done(layer_done),
        .layers_run(layers_run)
`ifdef NN_SEQ_PERF_EN
        , .perf_cycles(perf_cycles)
`endif
    );

    typedef struct {
        logic [7:0] in_s;
        logic [7:0] out_s;
        logic [7:0] idx;
    } desc_t;

    typedef struct {
        logic [0:4][7:0] prog;
        int              code;
        int              nl;
    } vec_t;

    desc_t got_q[$];
    desc_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    phase = 0, wcnt = 0, dcnt = 0;
    int    rdy_delay = 0, done_delay = 3;
    bit    manual = 0, spur = 0;
    int    done_cnt = 0, busy_cnt = 0;
    bit    addr_bad = 0;
    int    mcode, mnl;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: consecutive entries pair into layers, scanned until a
    // terminator, a zero, or the last RAM entry.
    task automatic model(input logic [0:4][7:0] p,
                         output int code, output int nl);
        code = 0;
        nl = 0;
        exp_q.delete();
        if (p[0] == 8'hFF) code = 1;
        else if (p[0] == 8'h00) code = 2;
        else begin
            for (int k = 1; k < DEPTH; k++) begin
                if (p[k] == 8'hFF) begin
                    if (k == 1) code = 1;
                    break;
                end
                if (p[k] == 8'h00) begin
                    code = 2;
                    break;
                end
                exp_q.push_back('{p[k-1], p[k], 8'(k - 1)});
                nl++;
                if (k == DEPTH - 1) code = 3;
            end
        end
    endtask

    // Datapath responder: ready after rdy_delay cycles of valid,
    // layer_done pulse done_delay cycles after the transfer.
    initial begin
        layer_ready = 1'b0;
        layer_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!manual) begin
                layer_done = 1'b0;
                layer_ready = 1'b0;
                if (phase == 1) begin
                    if (dcnt == 0) begin
                        layer_done = 1'b1;
                        phase = 0;
                    end else dcnt--;
                end else if (layer_valid) begin
                    if (wcnt >= rdy_delay) begin
                        layer_ready = 1'b1;
                        got_q.push_back('{layer_in_size, layer_out_size,
                                          layer_idx});
                        wcnt = 0;
                        phase = 1;
                        dcnt = done_delay;
                    end else wcnt++;
                end else if (spur) begin
                    layer_ready = ($urandom_range(3) == 0);
                    layer_done = ($urandom_range(3) == 0);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (imem_en && imem_addr >= 8'(DEPTH)) addr_bad = 1;
        end
    end

    task automatic begin_run(input logic [0:4][7:0] p);
        for (int i = 0; i < DEPTH; i++) mem[i] = p[i];
        got_q.delete();
        done_cnt = 0;
        busy_cnt = 0;
        addr_bad = 0;
        phase = 0;
        wcnt = 0;
        model(p, mcode, mnl);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic end_run(input int ecode, input int enl, input string nm);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " timeout"}, int'(n >= 2000), 0);
        chk({nm, " error"}, int'(error), int'(ecode != 0));
        chk({nm, " error_code"}, int'(error_code), ecode);
        chk({nm, " layers_run"}, int'(layers_run), enl);
        chk({nm, " done_pulses"}, done_cnt, int'(ecode == 0));
        chk({nm, " addr_range"}, int'(addr_bad), 0);
        chk({nm, " n_desc"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s desc%0d", nm, i),
                int'({got_q[i].in_s, got_q[i].out_s, got_q[i].idx}),
                int'({exp_q[i].in_s, exp_q[i].out_s, exp_q[i].idx}));
`ifdef NN_SEQ_PERF_EN
        chk({nm, " perf_cycles"}, int'(perf_cycles), busy_cnt);
`endif
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " busy"}, int'(busy), 0);
        chk({nm, " done"}, int'(done), 0);
        chk({nm, " error"}, int'(error), 0);
        chk({nm, " error_code"}, int'(error_code), 0);
        chk({nm, " imem_en"}, int'(imem_en), 0);
        chk({nm, " imem_addr"}, int'(imem_addr), 0);
        chk({nm, " valid"}, int'(layer_valid), 0);
        chk({nm, " sizes"}, int'({layer_in_size, layer_out_size}), 0);
        chk({nm, " idx"}, int'(layer_idx), 0);
        chk({nm, " layers_run"}, int'(layers_run), 0);
`ifdef NN_SEQ_PERF_EN
        chk({nm, " perf"}, int'(perf_cycles), 0);
`endif
    endtask

    vec_t vecs [8];
    logic [0:4][7:0] p;
    logic [0:4][7:0] okp;
    int n;

    initial begin
        vecs[0] = '{'{8'd4, 8'd3, 8'd8, 8'd5, 8'hFF}, 0, 3};
        vecs[1] = '{'{8'hFF, 8'd1, 8'd2, 8'd3, 8'd4}, 1, 0};
        vecs[2] = '{'{8'd4, 8'hFF, 8'd2, 8'd3, 8'd4}, 1, 0};
        vecs[3] = '{'{8'd4, 8'd0, 8'd2, 8'd3, 8'd4}, 2, 0};
        vecs[4] = '{'{8'd0, 8'd7, 8'd2, 8'd3, 8'hFF}, 2, 0};
        vecs[5] = '{'{8'd4, 8'd3, 8'd8, 8'd5, 8'd6}, 3, 4};
        vecs[6] = '{'{8'd7, 8'd9, 8'hFF, 8'd3, 8'd4}, 0, 1};
        vecs[7] = '{'{8'd2, 8'd5, 8'd0, 8'd3, 8'd4}, 2, 1};
        okp = vecs[0].prog;

        rst = 1'b1;
        start = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'hFF;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            begin_run(vecs[v].prog);
            end_run(vecs[v].code, vecs[v].nl, $sformatf("vec%0d", v));
        end

        // Descriptor held while the datapath stalls; start and layer_done
        // during the stall must be ignored.
        manual = 1;
        layer_ready = 1'b0;
        layer_done = 1'b0;
        begin_run(okp);
        n = 0;
        while (!layer_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall reach_valid", int'(layer_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = (i == 1);
            layer_done = (i == 3);
            chk($sformatf("stall valid%0d", i), int'(layer_valid), 1);
            chk($sformatf("stall desc%0d", i),
                int'({layer_in_size, layer_out_size, layer_idx}),
                int'({8'd4, 8'd3, 8'd0}));
        end
        start = 1'b0;
        layer_done = 1'b0;
        wcnt = 0;
        phase = 0;
        manual = 0;
        end_run(0, 3, "stall");

        // Reset during WAIT_DONE of the second layer, then rerun.
        done_delay = 10;
        begin_run(okp);
        n = 0;
        while (got_q.size() < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rstwait layers_run", int'(layers_run), 1);
        @(negedge clk);
        manual = 1;
        layer_done = 1'b0;
        layer_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_zero("midrst");
        phase = 0;
        wcnt = 0;
        manual = 0;
        done_delay = 3;
        begin_run(okp);
        end_run(0, 3, "rerun");

        spur = 1;
        for (int r = 0; r < 40; r++) begin
            rdy_delay = $urandom_range(3);
            done_delay = $urandom_range(4);
            for (int i = 0; i < DEPTH; i++) begin
                n = $urandom_range(99);
                if (n < 15) p[i] = 8'hFF;
                else if (n < 22) p[i] = 8'h00;
                else p[i] = 8'($urandom_range(254, 1));
            end
            begin_run(p);
            end_run(mcode, mnl, $sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
